// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle RV32I main control FSM.
// State enum, opcode constants, mux/ALU select encodings and the control word.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BEQ,
    S_JAL
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  typedef struct packed {
    logic       adr_src;
    logic       ir_write;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] result_src;
    logic       pc_update;
    logic       branch;
    logic       instr_done;
  } ctrl_t;

  function automatic logic op_supported(input logic [6:0] op);
    return (op == OP_LW) || (op == OP_SW) || (op == OP_R) ||
           (op == OP_I) || (op == OP_BEQ) || (op == OP_JAL);
  endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Moore control word for each state of the main control FSM.
// Purely combinational; strobe gating is applied by the parent.
module mc_ctrl_decode
  import mc_pkg::*;
(
  input  state_t state,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    unique case (state)
      S_FETCH: begin
        ctrl.adr_src    = 1'b0;
        ctrl.ir_write   = 1'b1;
        ctrl.alu_src_a  = SRCA_PC;
        ctrl.alu_src_b  = SRCB_FOUR;
        ctrl.alu_op     = ALU_ADD;
        ctrl.result_src = RES_ALURES;
        ctrl.pc_update  = 1'b1;
      end
      S_DECODE: begin
        ctrl.alu_src_a = SRCA_OLDPC;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
      end
      S_MEMADR: begin
        ctrl.alu_src_a = SRCA_RS1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
      end
      S_MEMREAD: begin
        ctrl.adr_src    = 1'b1;
        ctrl.result_src = RES_ALUOUT;
      end
      S_MEMWB: begin
        ctrl.result_src = RES_DATA;
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_MEMWRITE: begin
        ctrl.adr_src    = 1'b1;
        ctrl.result_src = RES_ALUOUT;
        ctrl.mem_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_EXECR: begin
        ctrl.alu_src_a = SRCA_RS1;
        ctrl.alu_src_b = SRCB_RS2;
        ctrl.alu_op    = ALU_FUNCT;
      end
      S_EXECI: begin
        ctrl.alu_src_a = SRCA_RS1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_FUNCT;
      end
      S_ALUWB: begin
        ctrl.result_src = RES_ALUOUT;
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_BEQ: begin
        ctrl.alu_src_a  = SRCA_RS1;
        ctrl.alu_src_b  = SRCB_RS2;
        ctrl.alu_op     = ALU_SUB;
        ctrl.result_src = RES_ALUOUT;
        ctrl.branch     = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_JAL: begin
        ctrl.alu_src_a  = SRCA_OLDPC;
        ctrl.alu_src_b  = SRCB_FOUR;
        ctrl.alu_op     = ALU_ADD;
        ctrl.result_src = RES_ALUOUT;
        ctrl.pc_update  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mc_main_fsm.sv
// Main control FSM of the multicycle RV32I core: state register, next-state
// logic, pc_write and reset gating. MC_FSM_STALL_EN adds mem_ready holds.
module mc_main_fsm
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       adr_src,
  output logic       ir_write,
  output logic       mem_write,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] result_src,
  output logic       illegal_op,
  output logic       instr_done
);

  state_t state, state_next, dec_state;
  ctrl_t  ctrl;
  logic   mem_ack;
  logic   fetch_ok;
  logic   write_ok;

`ifdef MC_FSM_STALL_EN
  assign mem_ack = mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
  assign mem_ack          = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= state_next;
  end

  always_comb begin
    state_next = S_FETCH;
    unique case (state)
      S_FETCH:    state_next = mem_ack ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if ((op == OP_LW) || (op == OP_SW)) state_next = S_MEMADR;
        else if (op == OP_R)                state_next = S_EXECR;
        else if (op == OP_I)                state_next = S_EXECI;
        else if (op == OP_BEQ)              state_next = S_BEQ;
        else if (op == OP_JAL)              state_next = S_JAL;
        else                                state_next = S_FETCH;
      end
      S_MEMADR:   state_next = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  state_next = mem_ack ? S_MEMWB : S_MEMREAD;
      S_MEMWRITE: state_next = mem_ack ? S_FETCH : S_MEMWRITE;
      S_EXECR:    state_next = S_ALUWB;
      S_EXECI:    state_next = S_ALUWB;
      default:    state_next = S_FETCH;
    endcase
  end

  // Under reset the selects show FETCH values while every strobe is held low.
  assign dec_state = reset ? S_FETCH : state;

  mc_ctrl_decode u_decode (
    .state (dec_state),
    .ctrl  (ctrl)
  );

  assign fetch_ok = (state != S_FETCH) || mem_ack;
  assign write_ok = (state != S_MEMWRITE) || mem_ack;

  assign adr_src    = ctrl.adr_src;
  assign alu_src_a  = ctrl.alu_src_a;
  assign alu_src_b  = ctrl.alu_src_b;
  assign alu_op     = ctrl.alu_op;
  assign result_src = ctrl.result_src;

  assign ir_write   = !reset && ctrl.ir_write && fetch_ok;
  assign pc_write   = !reset && ((ctrl.pc_update && fetch_ok) || (ctrl.branch && zero));
  assign mem_write  = !reset && ctrl.mem_write;
  assign reg_write  = !reset && ctrl.reg_write;
  assign instr_done = !reset && ctrl.instr_done && write_ok;
  assign illegal_op = !reset && (state == S_DECODE) && !op_supported(op);

endmodule

// File: tb/tb_mc_main_fsm.sv
// Directed self-checking bench for mc_main_fsm: the full output word is
// compared each cycle against hand-derived per-state values.
module tb_mc_main_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic       zero;
  logic       mem_ready;
  logic       pc_write, adr_src, ir_write, mem_write, reg_write;
  logic [1:0] alu_src_a, alu_src_b, alu_op, result_src;
  logic       illegal_op, instr_done;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  always #5 clk = ~clk;

  mc_main_fsm dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .pc_write   (pc_write),
    .adr_src    (adr_src),
    .ir_write   (ir_write),
    .mem_write  (mem_write),
    .reg_write  (reg_write),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .result_src (result_src),
    .illegal_op (illegal_op),
    .instr_done (instr_done)
  );

  // {pc_write, adr_src, ir_write, mem_write, reg_write, src_a, src_b, alu_op, result_src, illegal_op, instr_done}
  localparam logic [14:0] W_RST      = 15'b0_0_0_0_0_00_10_00_10_0_0;
  localparam logic [14:0] W_FETCH    = 15'b1_0_1_0_0_00_10_00_10_0_0;
  localparam logic [14:0] W_DEC      = 15'b0_0_0_0_0_01_01_00_00_0_0;
  localparam logic [14:0] W_DEC_ILL  = 15'b0_0_0_0_0_01_01_00_00_1_0;
  localparam logic [14:0] W_MADR     = 15'b0_0_0_0_0_10_01_00_00_0_0;
  localparam logic [14:0] W_MRD      = 15'b0_1_0_0_0_00_00_00_00_0_0;
  localparam logic [14:0] W_MWB      = 15'b0_0_0_0_1_00_00_00_01_0_1;
  localparam logic [14:0] W_MWR      = 15'b0_1_0_1_0_00_00_00_00_0_1;
  localparam logic [14:0] W_EXR      = 15'b0_0_0_0_0_10_00_10_00_0_0;
  localparam logic [14:0] W_EXI      = 15'b0_0_0_0_0_10_01_10_00_0_0;
  localparam logic [14:0] W_AWB      = 15'b0_0_0_0_1_00_00_00_00_0_1;
  localparam logic [14:0] W_BEQ_T    = 15'b1_0_0_0_0_10_00_01_00_0_1;
  localparam logic [14:0] W_BEQ_N    = 15'b0_0_0_0_0_10_00_01_00_0_1;
  localparam logic [14:0] W_JAL      = 15'b1_0_0_0_0_01_10_00_00_0_1;
`ifdef MC_FSM_STALL_EN
  localparam logic [14:0] W_FETCH_ST = 15'b0_0_0_0_0_00_10_00_10_0_0;
  localparam logic [14:0] W_MWR_HOLD = 15'b0_1_0_1_0_00_00_00_00_0_0;
`endif

  logic [14:0] obs_word;
  assign obs_word = {pc_write, adr_src, ir_write, mem_write, reg_write,
                     alu_src_a, alu_src_b, alu_op, result_src, illegal_op, instr_done};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %b, want %b", tag, obs[14:0], exp[14:0]);
  endtask

  // Inputs are set just after a negedge; outputs sampled 1 time unit later,
  // then the bench advances to the next negedge across one rising edge.
  task automatic cyc(input string tag, input logic [14:0] exp);
    #1;
    check(tag, {17'd0, obs_word}, {17'd0, exp});
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    op        = 7'b0110011;
    zero      = 1'b1;
    mem_ready = 1'b1;
    @(negedge clk);
    cyc("rst0", W_RST);
    cyc("rst1", W_RST);
    reset = 1'b0;

    // lw: 5 cycles
    op = 7'b0000011; zero = 1'b0;
    cyc("lw_fetch",  W_FETCH);
    cyc("lw_decode", W_DEC);
    cyc("lw_madr",   W_MADR);
    cyc("lw_mrd",    W_MRD);
    cyc("lw_mwb",    W_MWB);

    // sw: 4 cycles
    op = 7'b0100011;
    cyc("sw_fetch",  W_FETCH);
    cyc("sw_decode", W_DEC);
    cyc("sw_madr",   W_MADR);
    cyc("sw_mwr",    W_MWR);

    // beq taken then not taken
    op = 7'b1100011; zero = 1'b1;
    cyc("beq1_fetch",  W_FETCH);
    cyc("beq1_decode", W_DEC);
    cyc("beq1_exec",   W_BEQ_T);
    zero = 1'b0;
    cyc("beq0_fetch",  W_FETCH);
    cyc("beq0_decode", W_DEC);
    cyc("beq0_exec",   W_BEQ_N);

    // R-type then I-type
    op = 7'b0110011; zero = 1'b1;
    cyc("r_fetch",  W_FETCH);
    cyc("r_decode", W_DEC);
    cyc("r_exec",   W_EXR);
    cyc("r_wb",     W_AWB);
    op = 7'b0010011; zero = 1'b0;
    cyc("i_fetch",  W_FETCH);
    cyc("i_decode", W_DEC);
    cyc("i_exec",   W_EXI);
    cyc("i_wb",     W_AWB);

    // jal and an illegal opcode
    op = 7'b1101111;
    cyc("jal_fetch",  W_FETCH);
    cyc("jal_decode", W_DEC);
    cyc("jal_exec",   W_JAL);
    op = 7'b1111111;
    cyc("ill_fetch",  W_FETCH);
    cyc("ill_decode", W_DEC_ILL);
    op = 7'b0110011;
    cyc("ill_refetch", W_FETCH);
    cyc("ill_after",   W_DEC);
    cyc("ill_after_x", W_EXR);
    cyc("ill_after_w", W_AWB);

`ifdef MC_FSM_STALL_EN
    // fetch stall, then sw held in MEMWRITE for 3 extra cycles
    op = 7'b0100011; mem_ready = 1'b0;
    cyc("st_fetch_hold", W_FETCH_ST);
    mem_ready = 1'b1;
    cyc("st_fetch",  W_FETCH);
    cyc("st_decode", W_DEC);
    cyc("st_madr",   W_MADR);
    mem_ready = 1'b0;
    cyc("st_mwr_h1", W_MWR_HOLD);
    cyc("st_mwr_h2", W_MWR_HOLD);
    cyc("st_mwr_h3", W_MWR_HOLD);
    mem_ready = 1'b1;
    cyc("st_mwr_acc", W_MWR);
    cyc("st_next_fetch", W_FETCH);
    op = 7'b0000011;
    cyc("st_lw_decode", W_DEC);
    cyc("st_lw_madr",   W_MADR);
    mem_ready = 1'b0;
    cyc("st_mrd_hold",  W_MRD);
    mem_ready = 1'b1;
    cyc("st_mrd",       W_MRD);
    cyc("st_mwb",       W_MWB);
`endif

    // reset during MEMREAD of an lw abandons it
    op = 7'b0000011;
    cyc("rlw_fetch",  W_FETCH);
    cyc("rlw_decode", W_DEC);
    cyc("rlw_madr",   W_MADR);
    reset = 1'b1;
    cyc("rlw_reset",  W_RST);
    reset = 1'b0;
    cyc("rlw_refetch", W_FETCH);
    cyc("rlw_redecode", W_DEC);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mc_main_fsm.md
# mc_main_fsm

Main control state machine for the multicycle RV32I core. It sequences the shared datapath (PC, instruction register, register file, single ALU, unified instruction/data memory) through fetch, decode, execute, memory and writeback. Each state drives a Moore control word, including `ALUOp` into `alu_decoder`. When the stall feature is compiled in, memory-access states hold on a ready handshake.

## Interface
- No parameters.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `op`  in  7  opcode field of the instruction register, `instr[6:0]`.
- `zero`  in  1  ALU zero flag; used only to form `pc_write`.
- `mem_ready`  in  1  memory handshake; used only when `MC_FSM_STALL_EN` is defined.
- `pc_write`  out  1  PC load enable, equal to `PCUpdate | (Branch & zero)`.
- `adr_src`  out  1  memory address select: 0 = PC, 1 = ALUOut.
- `ir_write`  out  1  instruction register load.
- `mem_write`  out  1  memory write strobe.
- `reg_write`  out  1  register file write strobe.
- `alu_src_a`  out  2  ALU A mux select: 00 = PC, 01 = OldPC, 10 = rs1.
- `alu_src_b`  out  2  ALU B mux select: 00 = rs2, 01 = ImmExt, 10 = constant 4.
- `alu_op`  out  2  00 = add, 01 = sub, 10 = decode funct fields.
- `result_src`  out  2  result mux select: 00 = ALUOut, 01 = Data, 10 = ALUResult.
- `illegal_op`  out  1  one-cycle pulse in DECODE when `op` is unsupported.
- `instr_done`  out  1  one-cycle pulse in the final state of every instruction.

## Operation
- State encoding: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, JAL.
- Every state not listed below goes to FETCH on the next edge.
- DECODE transitions, by `op`:
  - 0000011 (lw) and 0100011 (sw) → MEMADR.
  - 0110011 → EXECR.
  - 0010011 → EXECI.
  - 1100011 → BEQ.
  - 1101111 → JAL.
  - Any other value → FETCH, with `illegal_op`=1 for that cycle.
- Other transitions: MEMADR → MEMREAD for lw, MEMWRITE for sw. MEMREAD → MEMWB. EXECR and EXECI → ALUWB.
- Control word per state. Any field not listed is 0.
  - FETCH: adr_src=0, ir_write=1, src_a=00, src_b=10, alu_op=00, result_src=10, PCUpdate=1.
  - DECODE: src_a=01, src_b=01, alu_op=00.
  - MEMADR: src_a=10, src_b=01, alu_op=00.
  - MEMREAD: adr_src=1, result_src=00.
  - MEMWB: result_src=01, reg_write=1.
  - MEMWRITE: adr_src=1, result_src=00, mem_write=1.
  - EXECR: src_a=10, src_b=00, alu_op=10.
  - EXECI: src_a=10, src_b=01, alu_op=10.
  - ALUWB: result_src=00, reg_write=1.
  - BEQ: src_a=10, src_b=00, alu_op=01, result_src=00, Branch=1.
  - JAL: src_a=01, src_b=10, alu_op=00, result_src=00, PCUpdate=1.
- `instr_done` asserts in MEMWB, MEMWRITE, ALUWB, BEQ and JAL.
- `op` is sampled only in DECODE and MEMADR. The instruction register is stable there because `ir_write`=0.

## Timing
- Moore outputs are combinational from the state register. `pc_write` and `illegal_op` also depend on the current-cycle inputs.
- Reset: state returns to FETCH at the next edge.
  - While `reset`=1, these outputs are forced to 0 combinationally: `ir_write`, `pc_write`, `mem_write`, `reg_write`, `illegal_op`, `instr_done`.
  - Mux selects follow FETCH values.
  - Reset mid-instruction abandons the instruction with no write.
- Latency with no stalls, in cycles: lw 5, sw 4, R-type 4, I-type 4, beq 3, jal 3, illegal 2.
- BEQ: `pc_write`=`zero` in that single cycle.
- Back-to-back instructions: FETCH follows the final state with no bubble.

## Configuration
- `MC_FSM_STALL_EN` defined:
  - FETCH and MEMREAD hold while `mem_ready`=0.
  - In FETCH, `ir_write` and `pc_write` assert only in the cycle where `mem_ready`=1.
  - MEMWRITE holds `mem_write`=1 until `mem_ready`=1. It exits, and `instr_done` pulses, only in the accepting cycle.
  - `mem_ready` is a same-cycle accept. It may be tied high.
- `MC_FSM_STALL_EN` undefined: `mem_ready` is ignored and every memory state takes exactly one cycle.

## Structure
- Package `mc_pkg` holds:
  - State enum.
  - Opcode constants: `OP_LW`, `OP_SW`, `OP_R`, `OP_I`, `OP_BEQ`, `OP_JAL`.
  - `alu_op`, `alu_src_a`, `alu_src_b` and `result_src` encodings.
- Sub-module `mc_ctrl_decode`: combinational state → control word. The top level keeps the state register, the next-state logic and the `pc_write`/reset gating.

## Test plan
- Reset for 2 cycles, then release → state is FETCH, all strobes 0 during reset, `ir_write`=1 on the first cycle after release.
- Feed `op`=0000011 → FETCH, DECODE, MEMADR, MEMREAD, MEMWB; `reg_write` and `result_src`=01 only in cycle 5; `instr_done` pulses in cycle 5.
- Feed `op`=1100011 twice, with `zero`=1 then `zero`=0 → `pc_write`=1 in the BEQ cycle of the first instruction, 0 in the second; `alu_op`=01.
- Feed `op`=0110011, then `op`=1111111 → R-type completes in 4 cycles with `alu_op`=10 and `alu_src_b`=00; the illegal opcode pulses `illegal_op` in DECODE and returns to FETCH with no write.
- With `MC_FSM_STALL_EN`, run sw with `mem_ready` low for 3 cycles in MEMWRITE → `mem_write` held for 4 cycles; `instr_done` only in the 4th; FETCH follows.
- Assert `reset` in MEMREAD of an lw → no `reg_write`; FETCH resumes after release.
